// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data-memory arbiter:
//                arbiter state encoding, port identifiers and a one-hot
//                port helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    // Arbiter sequencing state; one bit is enough for the two states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Port identifiers. Port 0 is the pipeline MEM stage, port 1 the DMA/loader.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // One-hot completion vector for a given port index.
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_rr_pick
//  Description : Combinational two-way round-robin picker. A single valid
//                requester always wins; when both are valid, the port that
//                did not win last time is chosen.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_gnt,
    output logic       any,
    output logic       winner
);

    // Pick the winner; on a tie the previously granted port yields.
    always_comb begin
        any    = |valid;
        winner = PORT_CPU;
        if (valid == 2'b11) begin
            winner = ~last_gnt;
        end else if (valid[PORT_DMA]) begin
            winner = PORT_DMA;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single DataMemory port between the pipeline MEM
//                stage (port 0) and the DMA/loader (port 1). The winning
//                request is latched at grant and presented to memory for
//                ACCESS_CYCLES cycles; completion is a one-cycle ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic              reset,
    input  logic              clk,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_rdata,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_dout,

    output logic              busy
);

    // Counter reload value and decrement step.
    localparam logic [CNT_W-1:0] CNT_LOAD      = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    // With single-cycle accesses the grant cycle is immediately followed by
    // the completion cycle, so the final-cycle outputs are set at grant.
    localparam logic             LAST_AT_GRANT = (ACCESS_CYCLES == 1);

    arb_state_t        r_state;
    logic              r_gnt;
    logic              r_last_gnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_lat_write;
    logic [ADDR_W-1:0] r_lat_addr;
    logic [DATA_W-1:0] r_lat_wdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [1:0]        r_ready;

    logic              w_any;
    logic              w_winner;
    logic              w_win_write;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic [1:0]        w_ready;

    dmem_arb_rr_pick u_pick (
        .valid    ({req1_valid, req0_valid}),
        .last_gnt (r_last_gnt),
        .any      (w_any),
        .winner   (w_winner)
    );

    // Payload of whichever port the picker selected this cycle.
    always_comb begin
        w_win_write = req0_write;
        w_win_addr  = req0_addr;
        w_win_wdata = req0_wdata;
        if (w_winner == PORT_DMA) begin
            w_win_write = req1_write;
            w_win_addr  = req1_addr;
            w_win_wdata = req1_wdata;
        end
    end

    // Grant / sequencing FSM with latched payload and registered memory controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt       <= PORT_CPU;
            r_last_gnt  <= PORT_DMA;
            r_cnt       <= '0;
            r_lat_write <= 1'b0;
            r_lat_addr  <= '0;
            r_lat_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ready     <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= BUSY;
                        r_gnt       <= w_winner;
                        r_last_gnt  <= w_winner;
                        r_cnt       <= CNT_LOAD;
                        r_lat_write <= w_win_write;
                        r_lat_addr  <= w_win_addr;
                        r_lat_wdata <= w_win_wdata;
                        r_mem_read  <= ~w_win_write;
                        r_mem_write <= w_win_write & LAST_AT_GRANT;
                        r_ready     <= LAST_AT_GRANT ? port_onehot(w_winner) : 2'b00;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                        // Entering the final cycle: strobe the write and the ready pulse.
                        if (r_cnt == CNT_ONE) begin
                            r_mem_write <= r_lat_write;
                            r_ready     <= port_onehot(r_gnt);
                        end
                    end else begin
                        // Access complete; everything returns to zero in IDLE.
                        r_state     <= IDLE;
                        r_lat_write <= 1'b0;
                        r_lat_addr  <= '0;
                        r_lat_wdata <= '0;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_ready     <= 2'b00;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A reset arriving in the final cycle aborts the access: the write strobe
    // and the ready pulse are suppressed at that same edge.
    assign w_ready    = r_ready & {2{~reset}};
    assign mem_write  = r_mem_write & ~reset;
    assign mem_read   = r_mem_read;
    assign mem_addr   = r_lat_addr;
    assign mem_din    = r_lat_wdata;
    assign busy       = (r_state == BUSY);

    assign req0_ready = w_ready[PORT_CPU];
    assign req1_ready = w_ready[PORT_DMA];

    // Read data is taken straight from the combinational memory output and is
    // only non-zero for the granted port's load completion.
    assign req0_rdata = (w_ready[PORT_CPU] && !r_lat_write) ? mem_dout : '0;
    assign req1_rdata = (w_ready[PORT_DMA] && !r_lat_write) ? mem_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. Instance A uses
//                ACCESS_CYCLES=2, instance B ACCESS_CYCLES=1; each has its
//                own word-indexed memory model and a reference copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AC_A = 2;
    localparam int AC_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        init_mem;
    logic [31:0] seed;
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    logic        a_v0, a_w0, a_r0, a_v1, a_w1, a_r1;
    logic [31:0] a_ad0, a_wd0, a_rd0, a_ad1, a_wd1, a_rd1;
    logic [31:0] a_maddr, a_mdin, a_mdout;
    logic        a_mrd, a_mwr, a_busy;

    logic        b_v0, b_w0, b_r0, b_v1, b_w1, b_r1;
    logic [31:0] b_ad0, b_wd0, b_rd0, b_ad1, b_wd1, b_rd1;
    logic [31:0] b_maddr, b_mdin, b_mdout;
    logic        b_mrd, b_mwr, b_busy;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] ref_a [256];
    logic [31:0] ref_b [256];

    function automatic logic [31:0] init_word(input int i, input logic [31:0] s);
        return (32'(i) * 32'h9E37_79B9) ^ s;
    endfunction

    // DataMemory models: combinational read, write on posedge.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i, seed);
            mem_a[16] <= 32'hDEAD_BEEF;
        end else if (a_mwr) begin
            mem_a[a_maddr[9:2]] <= a_mdin;
        end
    end
    assign a_mdout = mem_a[a_maddr[9:2]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i, ~seed);
        end else if (b_mwr) begin
            mem_b[b_maddr[9:2]] <= b_mdin;
        end
    end
    assign b_mdout = mem_b[b_maddr[9:2]];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(AC_A), .CNT_W(4)) u_dut_a (
        .reset(reset), .clk(clk),
        .req0_valid(a_v0), .req0_write(a_w0), .req0_addr(a_ad0), .req0_wdata(a_wd0),
        .req0_ready(a_r0), .req0_rdata(a_rd0),
        .req1_valid(a_v1), .req1_write(a_w1), .req1_addr(a_ad1), .req1_wdata(a_wd1),
        .req1_ready(a_r1), .req1_rdata(a_rd1),
        .mem_addr(a_maddr), .mem_din(a_mdin), .mem_read(a_mrd), .mem_write(a_mwr),
        .mem_dout(a_mdout), .busy(a_busy)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(AC_B), .CNT_W(4)) u_dut_b (
        .reset(reset), .clk(clk),
        .req0_valid(b_v0), .req0_write(b_w0), .req0_addr(b_ad0), .req0_wdata(b_wd0),
        .req0_ready(b_r0), .req0_rdata(b_rd0),
        .req1_valid(b_v1), .req1_write(b_w1), .req1_addr(b_ad1), .req1_wdata(b_wd1),
        .req1_ready(b_r1), .req1_rdata(b_rd1),
        .mem_addr(b_maddr), .mem_din(b_mdin), .mem_read(b_mrd), .mem_write(b_mwr),
        .mem_dout(b_mdout), .busy(b_busy)
    );

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One request on instance A; returns latency from first valid cycle to ready,
    // the number of mem_write cycles and ready pulses seen on the other port.
    task automatic a_access(input int p, input logic w, input logic [31:0] ad,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output int lat, output int nwr, output int noth);
        lat = -1; nwr = 0; noth = 0; rd = '0;
        next_cycle();
        if (p == 0) begin a_v0 = 1'b1; a_w0 = w; a_ad0 = ad; a_wd0 = wd; end
        else        begin a_v1 = 1'b1; a_w1 = w; a_ad1 = ad; a_wd1 = wd; end
        for (int c = 0; c < 20 && lat < 0; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            if (a_mwr) nwr++;
            if ((p == 0) ? a_r1 : a_r0) noth++;
            if ((p == 0) ? a_r0 : a_r1) begin
                lat = c;
                rd  = (p == 0) ? a_rd0 : a_rd1;
            end
        end
        next_cycle();
        a_v0 = 1'b0; a_v1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; init_mem = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (a_busy !== 1'b0 || a_mrd !== 1'b0 || a_mwr !== 1'b0 || a_maddr !== 32'h0 || a_mdin !== 32'h0)
            $display("FAIL reset_mem_if: busy=%b rd=%b wr=%b addr=%h din=%h, want all 0", a_busy, a_mrd, a_mwr, a_maddr, a_mdin);
        else pass_cnt++;
        total_cnt++;
        if (a_r0 !== 1'b0 || a_r1 !== 1'b0 || a_rd0 !== 32'h0 || a_rd1 !== 32'h0 || b_busy !== 1'b0)
            $display("FAIL reset_ports: r0=%b r1=%b rd0=%h rd1=%h b_busy=%b, want all 0", a_r0, a_r1, a_rd0, a_rd1, b_busy);
        else pass_cnt++;
    endtask

    task automatic test_load();
        next_cycle();
        a_v0 = 1'b1; a_w0 = 1'b0; a_ad0 = 32'h40; a_wd0 = $urandom;
        @(negedge clk);
        total_cnt++;
        if (a_mrd !== 1'b0 || a_r0 !== 1'b0)
            $display("FAIL load_t0: mem_read=%b ready=%b, want 0 0", a_mrd, a_r0);
        else pass_cnt++;
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            @(negedge clk);
            total_cnt++;
            if (a_mrd !== 1'b1 || a_maddr !== 32'h40 || a_mwr !== 1'b0)
                $display("FAIL load_mem t+%0d: read=%b addr=%h write=%b, want 1 40 0", k, a_mrd, a_maddr, a_mwr);
            else pass_cnt++;
            total_cnt++;
            if (a_r0 !== 1'(k == 2))
                $display("FAIL load_ready t+%0d: got %b want %b", k, a_r0, 1'(k == 2));
            else pass_cnt++;
            if (k == 2) begin
                total_cnt++;
                if (a_rd0 !== 32'hDEAD_BEEF)
                    $display("FAIL load_rdata: got %h want deadbeef", a_rd0);
                else pass_cnt++;
            end
        end
        next_cycle();
        a_v0 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (a_r0 !== 1'b0 || a_busy !== 1'b0 || a_mrd !== 1'b0)
            $display("FAIL load_after: ready=%b busy=%b read=%b, want 0 0 0", a_r0, a_busy, a_mrd);
        else pass_cnt++;
    endtask

    task automatic test_store();
        logic [31:0] rd;
        int lat, nwr, noth;
        a_access(1, 1'b1, 32'h80, 32'h1234_5678, rd, lat, nwr, noth);
        ref_a[32] = 32'h1234_5678;
        total_cnt++;
        if (lat !== AC_A || nwr !== 1 || noth !== 0 || rd !== 32'h0)
            $display("FAIL store_p1: lat=%0d writes=%0d other=%0d rdata=%h, want %0d 1 0 0", lat, nwr, noth, rd, AC_A);
        else pass_cnt++;
        a_access(0, 1'b0, 32'h80, $urandom, rd, lat, nwr, noth);
        total_cnt++;
        if (lat !== AC_A || rd !== 32'h1234_5678 || nwr !== 0)
            $display("FAIL store_readback: lat=%0d rdata=%h writes=%0d, want %0d 12345678 0", lat, rd, nwr, AC_A);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] rd, ad, wd, exp_rd;
        logic        w;
        int          p, lat, nwr, noth;
        for (int n = 0; n < 10; n++) begin
            p  = int'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            ad = 32'($urandom_range(0, 255)) << 2;
            wd = $urandom;
            exp_rd = w ? 32'h0 : ref_a[ad[9:2]];
            a_access(p, w, ad, wd, rd, lat, nwr, noth);
            if (w) ref_a[ad[9:2]] = wd;
            total_cnt++;
            if (lat !== AC_A || rd !== exp_rd || nwr !== int'(w) || noth !== 0)
                $display("FAIL random[%0d] p%0d w=%b a=%h: lat=%0d rdata=%h writes=%0d other=%0d, want %0d %h %0d 0",
                         n, p, w, ad, lat, rd, nwr, noth, AC_A, exp_rd, int'(w));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_abort();
        next_cycle();
        a_v0 = 1'b1; a_w0 = 1'b1; a_ad0 = 32'h10; a_wd0 = ~ref_a[4];
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (a_busy !== 1'b1 || a_maddr !== 32'h10)
            $display("FAIL abort_busy: busy=%b addr=%h, want 1 10", a_busy, a_maddr);
        else pass_cnt++;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (a_mwr !== 1'b0 || a_r0 !== 1'b0)
            $display("FAIL abort_edge: write=%b ready=%b, want 0 0", a_mwr, a_r0);
        else pass_cnt++;
        next_cycle();
        reset = 1'b0; a_v0 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (a_busy !== 1'b0 || a_mrd !== 1'b0 || a_maddr !== 32'h0 || a_mdin !== 32'h0 || a_r0 !== 1'b0)
            $display("FAIL abort_after: busy=%b read=%b addr=%h din=%h ready=%b, want all 0", a_busy, a_mrd, a_maddr, a_mdin, a_r0);
        else pass_cnt++;
        total_cnt++;
        if (mem_a[4] !== ref_a[4])
            $display("FAIL abort_mem: mem[0x10]=%h want %h", mem_a[4], ref_a[4]);
        else pass_cnt++;
        next_cycle();
        a_v0 = 1'b1; a_w0 = 1'b0; a_ad0 = 32'h100;
        a_v1 = 1'b1; a_w1 = 1'b0; a_ad1 = 32'h200;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (a_maddr !== 32'h100)
            $display("FAIL abort_tie_grant: addr=%h want 100", a_maddr);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (a_r0 !== 1'b1 || a_r1 !== 1'b0 || a_rd0 !== ref_a[64])
            $display("FAIL abort_tie_done: r0=%b r1=%b rd0=%h, want 1 0 %h", a_r0, a_r1, a_rd0, ref_a[64]);
        else pass_cnt++;
        next_cycle();
        a_v0 = 1'b0; a_v1 = 1'b0;
        @(negedge clk);
    endtask

    // Both ports always valid: completions at AC + i*(AC+1), alternating 0,1,0,1.
    task automatic test_round_robin();
        logic        wr [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        logic [31:0] exp_rd, got_rd;
        logic [1:0]  renew;
        int          done, nwr, nst, cmp;
        do_reset();
        done = 0; nwr = 0; nst = 0; renew = 2'b11;
        for (int c = 0; c < 4 * (AC_A + 1); c++) begin
            next_cycle();
            for (int p = 0; p < 2; p++) begin
                if (renew[p]) begin
                    wr[p] = 1'($urandom_range(0, 1));
                    ad[p] = 32'($urandom_range(0, 255)) << 2;
                    wd[p] = $urandom;
                end
            end
            renew = 2'b00;
            a_v0 = 1'b1; a_w0 = wr[0]; a_ad0 = ad[0]; a_wd0 = wd[0];
            a_v1 = 1'b1; a_w1 = wr[1]; a_ad1 = ad[1]; a_wd1 = wd[1];
            @(negedge clk);
            if (a_mwr) nwr++;
            cmp = (c == AC_A + done * (AC_A + 1)) ? (done % 2) : -1;
            total_cnt++;
            if (a_r0 !== 1'(cmp == 0) || a_r1 !== 1'(cmp == 1))
                $display("FAIL rr_ready c=%0d: r0=%b r1=%b, want %b %b", c, a_r0, a_r1, 1'(cmp == 0), 1'(cmp == 1));
            else pass_cnt++;
            if (cmp >= 0) begin
                exp_rd = wr[cmp] ? 32'h0 : ref_a[ad[cmp][9:2]];
                got_rd = (cmp == 0) ? a_rd0 : a_rd1;
                total_cnt++;
                if (got_rd !== exp_rd)
                    $display("FAIL rr_rdata c=%0d p%0d: got %h want %h", c, cmp, got_rd, exp_rd);
                else pass_cnt++;
                if (wr[cmp]) begin
                    ref_a[ad[cmp][9:2]] = wd[cmp];
                    nst++;
                end
                renew[cmp] = 1'b1;
                done++;
            end
        end
        next_cycle();
        a_v0 = 1'b0; a_v1 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (nwr !== nst)
            $display("FAIL rr_writes: got %0d write cycles want %0d", nwr, nst);
        else pass_cnt++;
    endtask

    // ACCESS_CYCLES=1 instance: port 0 always valid, completion every 2nd cycle.
    task automatic test_back_to_back();
        logic [31:0] ad, exp_rd;
        logic        renew;
        int          done, cmp;
        done = 0; renew = 1'b1; ad = '0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            if (renew) ad = 32'($urandom_range(0, 255)) << 2;
            renew = 1'b0;
            b_v0 = 1'b1; b_w0 = 1'b0; b_ad0 = ad; b_wd0 = $urandom;
            @(negedge clk);
            cmp = (c == AC_B + done * (AC_B + 1)) ? 1 : 0;
            total_cnt++;
            if (b_r0 !== 1'(cmp) || b_mrd !== 1'(cmp) || b_r1 !== 1'b0)
                $display("FAIL b2b c=%0d: ready=%b read=%b r1=%b, want %b %b 0", c, b_r0, b_mrd, b_r1, 1'(cmp), 1'(cmp));
            else pass_cnt++;
            if (cmp == 1) begin
                exp_rd = ref_b[ad[9:2]];
                total_cnt++;
                if (b_rd0 !== exp_rd)
                    $display("FAIL b2b_rdata c=%0d: got %h want %h", c, b_rd0, exp_rd);
                else pass_cnt++;
                renew = 1'b1;
                done++;
            end
        end
        next_cycle();
        b_v0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_payload_change();
        next_cycle();
        a_v0 = 1'b1; a_w0 = 1'b0; a_ad0 = 32'h40;
        @(negedge clk);
        next_cycle();
        a_ad0 = 32'h44;
        @(negedge clk);
        total_cnt++;
        if (a_maddr !== 32'h40 || a_busy !== 1'b1)
            $display("FAIL payload_t1: addr=%h busy=%b, want 40 1", a_maddr, a_busy);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (a_maddr !== 32'h40 || a_r0 !== 1'b1 || a_rd0 !== ref_a[16])
            $display("FAIL payload_t2: addr=%h ready=%b rdata=%h, want 40 1 %h", a_maddr, a_r0, a_rd0, ref_a[16]);
        else pass_cnt++;
        next_cycle();
        a_v0 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (a_r0 !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL payload_after: ready=%b busy=%b, want 0 0", a_r0, a_busy);
        else pass_cnt++;
    endtask

    initial begin
        seed     = $urandom;
        reset    = 1'b1;
        init_mem = 1'b1;
        a_v0 = 0; a_w0 = 0; a_ad0 = 0; a_wd0 = 0; a_v1 = 0; a_w1 = 0; a_ad1 = 0; a_wd1 = 0;
        b_v0 = 0; b_w0 = 0; b_ad0 = 0; b_wd0 = 0; b_v1 = 0; b_w1 = 0; b_ad1 = 0; b_wd1 = 0;
        for (int i = 0; i < 256; i++) begin
            ref_a[i] = init_word(i, seed);
            ref_b[i] = init_word(i, ~seed);
        end
        ref_a[16] = 32'hDEAD_BEEF;
        test_reset();
        test_load();
        test_store();
        test_random();
        test_reset_abort();
        test_round_robin();
        test_back_to_back();
        test_payload_change();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
`default_nettype wire
